// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: redirect, stall, instruction-memory and IF/ID signals of the fetch stage
interface fetch_ctrl_if;
  logic        stall_req;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        ifid_write;
  logic        if_flush;
  modport master (
    input  stall_req, jump, jump_target, branch_taken, branch_target, imem_ready, imem_rdata,
    output pc, imem_req, imem_addr, instr_out, instr_pc, ifid_write, if_flush
  );
  modport slave (
    output stall_req, jump, jump_target, branch_taken, branch_target, imem_ready, imem_rdata,
    input  pc, imem_req, imem_addr, instr_out, instr_pc, ifid_write, if_flush
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with hold-off, wait states, stall buffering and redirect draining
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {HOLD, FETCH, DRAIN, STALL} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d, pend_q, pend_d, buf_q, buf_d, buf_pc_q, buf_pc_d;
  logic [31:0] instr_q, instr_d, instr_pc_q, instr_pc_d;
  logic        wr_q, wr_d, flush_q, flush_d;
  logic        redir;
  logic [31:0] tgt_raw, tgt;
  assign redir   = bus.jump | bus.branch_taken;
  assign tgt_raw = bus.jump ? bus.jump_target : bus.branch_target;
  assign tgt     = {tgt_raw[31:2], 2'b00};
  assign bus.imem_req   = reset & (state_q == FETCH | state_q == DRAIN);
  assign bus.imem_addr  = pc_q;
  assign bus.pc         = pc_q;
  assign bus.instr_out  = instr_q;
  assign bus.instr_pc   = instr_pc_q;
  assign bus.ifid_write = wr_q;
  assign bus.if_flush   = flush_q;
  // next-state: a redirect beats both a completing fetch and a stall; discarded words never reach IF/ID
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    buf_d      = buf_q;
    buf_pc_d   = buf_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    wr_d       = 1'b0;
    flush_d    = 1'b0;
    case (state_q)
      HOLD: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'(HOLD_CYCLES - 1)) ? FETCH : HOLD;
      end
      FETCH: begin
        if (redir) begin
          flush_d = 1'b1;
          pc_d    = bus.imem_ready ? tgt : pc_q;
          pend_d  = bus.imem_ready ? pend_q : tgt;
          state_d = bus.imem_ready ? FETCH : DRAIN;
        end else if (bus.imem_ready) begin
          pc_d = pc_q + 32'd4;
          if (bus.stall_req) begin
            buf_d    = bus.imem_rdata;
            buf_pc_d = pc_q;
            state_d  = STALL;
          end else begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_q;
            wr_d       = 1'b1;
          end
        end
      end
      DRAIN: begin
        flush_d = redir;
        pend_d  = redir ? tgt : pend_q;
        pc_d    = bus.imem_ready ? (redir ? tgt : pend_q) : pc_q;
        state_d = bus.imem_ready ? FETCH : DRAIN;
      end
      default: begin
        if (redir) begin
          flush_d = 1'b1;
          pc_d    = tgt;
          state_d = FETCH;
        end else if (!bus.stall_req) begin
          instr_d    = buf_q;
          instr_pc_d = buf_pc_q;
          wr_d       = 1'b1;
          state_d    = FETCH;
        end
      end
    endcase
  end
  // state registers; active-low synchronous reset abandons any request or buffered word
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      buf_q      <= '0;
      buf_pc_q   <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      wr_q       <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      buf_q      <= buf_d;
      buf_pc_q   <= buf_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      wr_q       <= wr_d;
      flush_q    <= flush_d;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard-based checks of fetch, wait, redirect, stall, wrap and reset behaviour
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total = 0;
  logic [31:0] exp_q[$];
  fetch_ctrl_if bus();
  fetch_ctrl #(.RESET_PC(32'h0), .HOLD_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_rdata = ~bus.imem_addr;
  // scoreboard: every IF/ID load must match the oldest expected pc and its memory word
  always @(negedge clk) begin
    if (bus.ifid_write && bus.if_flush) begin
      total++;
      $display("FAIL pulse_overlap: ifid_write=1 if_flush=1, required not both");
    end
    if (bus.ifid_write) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: instr_pc=%h, no write expected", bus.instr_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.instr_pc !== e || bus.instr_out !== ~e)
          $display("FAIL ifid_data: instr_pc=%h instr_out=%h, required %h/%h", bus.instr_pc, bus.instr_out, e, ~e);
        else passed++;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got %h, required %h", name, act, req);
    else passed++;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    bus.stall_req = 0; bus.jump = 0; bus.branch_taken = 0;
    bus.jump_target = 0; bus.branch_target = 0; bus.imem_ready = 1;
    tick(); tick();
    chk("reset_req", 32'(bus.imem_req), 0);
    chk("reset_pc", bus.pc, 0);
    chk("reset_instr", bus.instr_out, 0);
    chk("reset_pulses", {30'b0, bus.ifid_write, bus.if_flush}, 0);
  endtask
  task automatic test_hold_fetch();
    reset = 1'b1;
    tick();
    chk("hold_req", 32'(bus.imem_req), 0);
    tick();
    chk("first_req", 32'(bus.imem_req), 1);
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", bus.imem_addr, 32'(i * 4));
      exp_q.push_back(32'(i * 4));
      tick();
    end
  endtask
  task automatic test_wait();
    bus.imem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      chk("wait_addr", bus.imem_addr, 32'h10);
      tick();
    end
    bus.imem_ready = 1;
    chk("wait_addr_last", bus.imem_addr, 32'h10);
    exp_q.push_back(32'h10);
    tick();
    chk("after_wait_addr", bus.imem_addr, 32'h14);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h14 + 32'(i * 4));
      tick();
    end
  endtask
  task automatic test_redirect();
    chk("redir_start", bus.imem_addr, 32'h20);
    bus.imem_ready = 0;
    bus.jump = 1; bus.jump_target = 32'h100;
    bus.branch_taken = 1; bus.branch_target = 32'h200;
    tick();
    bus.jump = 0; bus.branch_taken = 0;
    chk("drain_flush", 32'(bus.if_flush), 1);
    chk("drain_addr", bus.imem_addr, 32'h20);
    tick();
    chk("drain_flush_once", 32'(bus.if_flush), 0);
    chk("drain_addr_held", {bus.imem_addr[31:1], bus.imem_req}, {31'h10, 1'b1});
    bus.imem_ready = 1;
    tick();
    chk("drain_target", bus.imem_addr, 32'h100);
    chk("drain_no_write", {30'b0, bus.ifid_write, bus.if_flush}, 0);
    bus.jump = 1; bus.jump_target = 32'h40;
    tick();
    bus.jump = 0;
    chk("jump_ready_addr", bus.imem_addr, 32'h40);
    chk("jump_ready_flush", {30'b0, bus.ifid_write, bus.if_flush}, 1);
  endtask
  task automatic test_stall();
    bus.stall_req = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_no_req", {30'b0, bus.imem_req, bus.ifid_write}, 0);
    end
    bus.stall_req = 0;
    exp_q.push_back(32'h40);
    tick();
    chk("stall_release_addr", bus.imem_addr, 32'h44);
    chk("stall_release_req", 32'(bus.imem_req), 1);
  endtask
  task automatic test_wrap();
    bus.jump = 1; bus.jump_target = 32'hFFFF_FFFC;
    tick();
    bus.jump = 0;
    chk("wrap_start", bus.imem_addr, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    tick();
    chk("wrap_addr", bus.imem_addr, 32'h0);
    bus.branch_taken = 1; bus.branch_target = 32'h103;
    tick();
    bus.branch_taken = 0;
    chk("align_addr", bus.imem_addr, 32'h100);
  endtask
  task automatic test_reset_drain();
    bus.imem_ready = 0;
    bus.branch_taken = 1; bus.branch_target = 32'h300;
    tick();
    bus.branch_taken = 0;
    reset = 1'b0;
    tick();
    chk("rst_drain_pc", bus.pc, 32'h0);
    chk("rst_drain_req", {30'b0, bus.imem_req, bus.if_flush}, 0);
    bus.imem_ready = 1;
    tick();
    bus.imem_ready = 0;
    chk("rst_late_ready", {bus.pc[31:1], bus.imem_req}, 0);
    reset = 1'b1;
    tick(); tick();
    chk("rst_refetch_addr", bus.imem_addr, 32'h0);
    chk("rst_refetch_req", 32'(bus.imem_req), 1);
    tick(); tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
  endtask
  initial begin
    test_reset();
    test_hold_fetch();
    test_wait();
    test_redirect();
    test_stall();
    test_wrap();
    test_reset_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: pc value loaded on reset.
REQ-002 Parameter HOLD_CYCLES, default 2: idle cycles after reset release before first fetch; range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 stall_req  input  1  ID-stage hazard stall; IF/ID register must not load.
REQ-006 jump  input  1  jump redirect request, valid with jump_target.
REQ-007 jump_target  input  32  jump destination.
REQ-008 branch_taken  input  1  taken-branch redirect request, valid with branch_target.
REQ-009 branch_target  input  32  branch destination.
REQ-010 imem_ready  input  1  instruction memory completes current request this cycle.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_req & imem_ready.
REQ-012 pc  output  32  current fetch PC (registered).
REQ-013 imem_req  output  1  instruction memory request strobe.
REQ-014 imem_addr  output  32  request address; equals pc whenever imem_req=1.
REQ-015 instr_out  output  32  instruction delivered to IF/ID (registered).
REQ-016 instr_pc  output  32  PC of instr_out (registered).
REQ-017 ifid_write  output  1  one-cycle pulse: IF/ID loads instr_out/instr_pc (registered).
REQ-018 if_flush  output  1  one-cycle pulse: IF/ID contents squashed (registered).

Function
REQ-019 States SHALL be HOLD, FETCH, DRAIN, STALL; state encoding is free.
REQ-020 HOLD: imem_req=0; counter increments each cycle; after HOLD_CYCLES cycles go FETCH; jump/branch_taken/stall_req ignored.
REQ-021 FETCH: imem_req=1 combinationally, imem_addr=pc; request held with stable address until imem_ready=1.
REQ-022 Fetch completes in the cycle imem_req=1 and imem_ready=1; zero-wait completion (ready in first FETCH cycle) SHALL be supported.
REQ-023 Completion, no redirect, stall_req=0: instr_out<=imem_rdata, instr_pc<=pc, ifid_write pulses next cycle, pc<=pc+4, remain FETCH (back-to-back fetch, one instruction per cycle at zero wait).
REQ-024 Completion, no redirect, stall_req=1: word buffered internally, pc<=pc+4, go STALL; ifid_write=0.
REQ-025 STALL: imem_req=0; first cycle with stall_req=0 loads buffered word to instr_out/instr_pc, pulses ifid_write next cycle, goes FETCH.
REQ-026 Redirect = jump | branch_taken; jump SHALL win when both are asserted; target low 2 bits forced to 0.
REQ-027 Redirect SHALL take priority over stall_req and over any completing fetch.
REQ-028 Redirect in FETCH with imem_ready=1: returned word discarded, pc<=target, remain FETCH.
REQ-029 Redirect in FETCH with imem_ready=0: target latched as pending, go DRAIN; request stays asserted at old address until imem_ready.
REQ-030 DRAIN: imem_req=1 at old address; on imem_ready word discarded, pc<=pending target, go FETCH; a new redirect in DRAIN overwrites pending target.
REQ-031 Redirect in STALL: buffered word discarded, pc<=target, go FETCH.
REQ-032 Every accepted redirect (FETCH, DRAIN, STALL) SHALL pulse if_flush for exactly the next cycle; a discarded word never produces ifid_write.
REQ-033 pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-034 ifid_write and if_flush SHALL never be 1 in the same cycle.

Reset
REQ-035 When reset=0 at a rising edge: state<=HOLD, hold counter<=0, pc<=RESET_PC, pending target<=0, instr_out<=0, instr_pc<=0, ifid_write<=0, if_flush<=0; imem_req=0 while reset=0.
REQ-036 Reset asserted mid-request (FETCH/DRAIN) or in STALL SHALL abandon the request and buffered word; a late imem_ready after reset is ignored.

Verification
REQ-037 Reset release, HOLD_CYCLES=2, imem_ready=1 always -> imem_req first high 2 cycles after release, addr 0,4,8,... and ifid_write pulses every cycle with instr_pc 0,4,8.
REQ-038 imem_ready delayed 3 cycles at pc=0x10 -> imem_addr stable 0x10 for 4 cycles, one ifid_write with instr_pc=0x10, next addr 0x14.
REQ-039 Same-cycle jump (target 0x100) and branch (target 0x200) while imem_ready=0 at pc=0x20 -> DRAIN, if_flush one cycle, on ready word discarded, next imem_addr 0x100, no ifid_write for 0x20.
REQ-040 stall_req high 3 cycles at completion of pc=0x40 -> no imem_req during stall, single ifid_write with instr_pc=0x40 after release, next fetch 0x44.
REQ-041 pc=0xFFFF_FFFC completes -> next imem_addr 0x0; branch_target 0x103 -> imem_addr 0x100.
REQ-042 reset=0 during DRAIN with pending target 0x300 -> pc=RESET_PC, imem_req=0, if_flush=0, no later fetch of 0x300.
